// File: rtl/vga_hex_overlay.sv
// vga_hex_overlay: draws a 3-line hex readout (A=, B=, R=) in a fixed box over 640x480 VGA, 2-strobe pipeline.
// Optional VGA_HEX_OVERLAY_ZERO_FLAG_EN: draws the R row green while the snapshotted result is zero.
module vga_hex_overlay #(
   parameter logic [9:0]  X0 = 10'd64,
   parameter logic [9:0]  Y0 = 10'd64,
   parameter logic [11:0] FG = 12'hFFF,
   parameter logic [11:0] BG = 12'h008
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic        pix_stb,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        de_in,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [15:0] result,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);
   localparam logic [9:0] X1 = X0 + 10'd192;
   localparam logic [9:0] Y1 = Y0 + 10'd96;

   logic [15:0] snap_a, snap_b, snap_r;
   logic        snap_now;
   assign snap_now = pix_stb && x == 10'd0 && y == 10'd480;

   // Sampled at the start of vertical blanking so the box never tears mid-frame.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         snap_a <= 16'h0;
         snap_b <= 16'h0;
         snap_r <= 16'h0;
      end else if (snap_now) begin
         snap_a <= op_a;
         snap_b <= op_b;
         snap_r <= result;
      end
   end

`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
   logic zflag;
   always_ff @(posedge CLK100MHZ) begin
      if (reset)
         zflag <= 1'b0;
      else if (snap_now)
         zflag <= result == 16'h0;
   end
`endif

   logic        in_box;
   logic [5:0]  dx;
   logic [4:0]  dy;
   logic [2:0]  col, fcol, frow;
   logic [1:0]  row;
   logic [15:0] row_val;
   logic [3:0]  nib;
   logic [4:0]  code;

   // dx/dy are box-relative coordinates in font-pixel units (4x4 screen pixels each).
   always_comb begin
      in_box  = x >= X0 && x < X1 && y >= Y0 && y < Y1;
      dx      = in_box ? 6'((x - X0) >> 2) : 6'd0;
      dy      = in_box ? 5'((y - Y0) >> 2) : 5'd0;
      {col, fcol} = dx;
      {row, frow} = dy;
      row_val = row == 2'd0 ? snap_a : row == 2'd1 ? snap_b : snap_r;
      nib     = col == 3'd2 ? row_val[15:12] : col == 3'd3 ? row_val[11:8] :
                col == 3'd4 ? row_val[7:4] : row_val[3:0];
      code    = !in_box ? 5'd31 :
                col == 3'd0 ? (row == 2'd0 ? 5'd10 : row == 2'd1 ? 5'd11 : 5'd17) :
                col == 3'd1 ? 5'd16 : {1'b0, nib};
   end

   logic [4:0] code_s1;
   logic [2:0] frow_s1, fcol_s1;
   logic       in_box_s1, de_s1, hs_s1, vs_s1;
`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
   logic       green_s1;
`endif

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         code_s1   <= 5'd0;
         frow_s1   <= 3'd0;
         fcol_s1   <= 3'd0;
         in_box_s1 <= 1'b0;
         de_s1     <= 1'b0;
         hs_s1     <= 1'b1;
         vs_s1     <= 1'b1;
`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
         green_s1  <= 1'b0;
`endif
      end else if (pix_stb) begin
         code_s1   <= code;
         frow_s1   <= frow;
         fcol_s1   <= fcol;
         in_box_s1 <= in_box;
         de_s1     <= de_in;
         hs_s1     <= hs_in;
         vs_s1     <= vs_in;
`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
         green_s1  <= in_box && row == 2'd2 && zflag;
`endif
      end
   end

   // Rows 0 and 7 of every glyph are blank, so only rows 1..6 are listed.
   logic [7:0] rom;
   always_comb begin
      rom = 8'h00;
      case ({code_s1, frow_s1})
         {5'd0, 3'd1}: rom = 8'h3C; {5'd0, 3'd2}: rom = 8'h66; {5'd0, 3'd3}: rom = 8'h6E; {5'd0, 3'd4}: rom = 8'h76; {5'd0, 3'd5}: rom = 8'h66; {5'd0, 3'd6}: rom = 8'h3C;
         {5'd1, 3'd1}: rom = 8'h18; {5'd1, 3'd2}: rom = 8'h38; {5'd1, 3'd3}: rom = 8'h18; {5'd1, 3'd4}: rom = 8'h18; {5'd1, 3'd5}: rom = 8'h18; {5'd1, 3'd6}: rom = 8'h7E;
         {5'd2, 3'd1}: rom = 8'h3C; {5'd2, 3'd2}: rom = 8'h66; {5'd2, 3'd3}: rom = 8'h0C; {5'd2, 3'd4}: rom = 8'h18; {5'd2, 3'd5}: rom = 8'h30; {5'd2, 3'd6}: rom = 8'h7E;
         {5'd3, 3'd1}: rom = 8'h3C; {5'd3, 3'd2}: rom = 8'h66; {5'd3, 3'd3}: rom = 8'h1C; {5'd3, 3'd4}: rom = 8'h06; {5'd3, 3'd5}: rom = 8'h66; {5'd3, 3'd6}: rom = 8'h3C;
         {5'd4, 3'd1}: rom = 8'h0C; {5'd4, 3'd2}: rom = 8'h1C; {5'd4, 3'd3}: rom = 8'h3C; {5'd4, 3'd4}: rom = 8'h6C; {5'd4, 3'd5}: rom = 8'h7E; {5'd4, 3'd6}: rom = 8'h0C;
         {5'd5, 3'd1}: rom = 8'h7E; {5'd5, 3'd2}: rom = 8'h60; {5'd5, 3'd3}: rom = 8'h7C; {5'd5, 3'd4}: rom = 8'h06; {5'd5, 3'd5}: rom = 8'h66; {5'd5, 3'd6}: rom = 8'h3C;
         {5'd6, 3'd1}: rom = 8'h3C; {5'd6, 3'd2}: rom = 8'h60; {5'd6, 3'd3}: rom = 8'h7C; {5'd6, 3'd4}: rom = 8'h66; {5'd6, 3'd5}: rom = 8'h66; {5'd6, 3'd6}: rom = 8'h3C;
         {5'd7, 3'd1}: rom = 8'h7E; {5'd7, 3'd2}: rom = 8'h06; {5'd7, 3'd3}: rom = 8'h0C; {5'd7, 3'd4}: rom = 8'h18; {5'd7, 3'd5}: rom = 8'h18; {5'd7, 3'd6}: rom = 8'h18;
         {5'd8, 3'd1}: rom = 8'h3C; {5'd8, 3'd2}: rom = 8'h66; {5'd8, 3'd3}: rom = 8'h3C; {5'd8, 3'd4}: rom = 8'h66; {5'd8, 3'd5}: rom = 8'h66; {5'd8, 3'd6}: rom = 8'h3C;
         {5'd9, 3'd1}: rom = 8'h3C; {5'd9, 3'd2}: rom = 8'h66; {5'd9, 3'd3}: rom = 8'h3E; {5'd9, 3'd4}: rom = 8'h06; {5'd9, 3'd5}: rom = 8'h0C; {5'd9, 3'd6}: rom = 8'h38;
         {5'd10, 3'd1}: rom = 8'h18; {5'd10, 3'd2}: rom = 8'h3C; {5'd10, 3'd3}: rom = 8'h66; {5'd10, 3'd4}: rom = 8'h7E; {5'd10, 3'd5}: rom = 8'h66; {5'd10, 3'd6}: rom = 8'h66;
         {5'd11, 3'd1}: rom = 8'h7C; {5'd11, 3'd2}: rom = 8'h66; {5'd11, 3'd3}: rom = 8'h7C; {5'd11, 3'd4}: rom = 8'h66; {5'd11, 3'd5}: rom = 8'h66; {5'd11, 3'd6}: rom = 8'h7C;
         {5'd12, 3'd1}: rom = 8'h3C; {5'd12, 3'd2}: rom = 8'h66; {5'd12, 3'd3}: rom = 8'h60; {5'd12, 3'd4}: rom = 8'h60; {5'd12, 3'd5}: rom = 8'h66; {5'd12, 3'd6}: rom = 8'h3C;
         {5'd13, 3'd1}: rom = 8'h78; {5'd13, 3'd2}: rom = 8'h6C; {5'd13, 3'd3}: rom = 8'h66; {5'd13, 3'd4}: rom = 8'h66; {5'd13, 3'd5}: rom = 8'h6C; {5'd13, 3'd6}: rom = 8'h78;
         {5'd14, 3'd1}: rom = 8'h7E; {5'd14, 3'd2}: rom = 8'h60; {5'd14, 3'd3}: rom = 8'h7C; {5'd14, 3'd4}: rom = 8'h60; {5'd14, 3'd5}: rom = 8'h60; {5'd14, 3'd6}: rom = 8'h7E;
         {5'd15, 3'd1}: rom = 8'h7E; {5'd15, 3'd2}: rom = 8'h60; {5'd15, 3'd3}: rom = 8'h7C; {5'd15, 3'd4}: rom = 8'h60; {5'd15, 3'd5}: rom = 8'h60; {5'd15, 3'd6}: rom = 8'h60;
         {5'd16, 3'd2}: rom = 8'h7E; {5'd16, 3'd4}: rom = 8'h7E;
         {5'd17, 3'd1}: rom = 8'h7C; {5'd17, 3'd2}: rom = 8'h66; {5'd17, 3'd3}: rom = 8'h7C; {5'd17, 3'd4}: rom = 8'h78; {5'd17, 3'd5}: rom = 8'h6C; {5'd17, 3'd6}: rom = 8'h66;
         default: rom = 8'h00;
      endcase
   end

   logic        pix_on;
   logic [11:0] fg, rgb;
   assign pix_on = rom[3'd7 - fcol_s1];
`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
   assign fg = green_s1 ? 12'h0F0 : FG;
`else
   assign fg = FG;
`endif

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         rgb    <= 12'h000;
         vga_hs <= 1'b1;
         vga_vs <= 1'b1;
      end else if (pix_stb) begin
         rgb    <= !de_s1 ? 12'h000 : in_box_s1 && pix_on ? fg : in_box_s1 ? BG : 12'h000;
         vga_hs <= hs_s1;
         vga_vs <= vs_s1;
      end
   end

   assign {vga_r, vga_g, vga_b} = rgb;
endmodule

// File: tb/tb_vga_hex_overlay.sv
// tb_vga_hex_overlay: randomized self-checking bench for vga_hex_overlay against a screen-level pixel model.
module tb_vga_hex_overlay;
   localparam int X0 = 64;
   localparam int Y0 = 64;
   localparam logic [11:0] FG = 12'hFFF;
   localparam logic [11:0] BG = 12'h008;
`ifdef VGA_HEX_OVERLAY_ZERO_FLAG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif
   localparam logic [13:0] IDLE = {12'h000, 1'b1, 1'b1};

   logic        clk = 1'b0;
   logic        reset = 1'b1, pix_stb = 1'b0, hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
   logic [9:0]  x = 10'd0, y = 10'd0;
   logic [15:0] op_a = 16'h0, op_b = 16'h0, result = 16'h0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs;

   int checks = 0;
   int failures = 0;
   logic [13:0] m_out = IDLE, m_s1 = IDLE;
   logic [15:0] ma = 16'h0, mb = 16'h0, mr = 16'h0;

   always #5 clk = ~clk;

   vga_hex_overlay #(.X0(10'(X0)), .Y0(10'(Y0)), .FG(FG), .BG(BG)) dut (
      .CLK100MHZ(clk), .reset(reset), .pix_stb(pix_stb), .x(x), .y(y),
      .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
      .op_a(op_a), .op_b(op_b), .result(result),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
   );

   // Each glyph as 8 bytes, top row in the most significant byte.
   function automatic logic [7:0] font_row(input int g, input int r);
      logic [63:0] v;
      case (g)
         0: v = 64'h003C666E76663C00;   1: v = 64'h0018381818187E00;
         2: v = 64'h003C660C18307E00;   3: v = 64'h003C661C06663C00;
         4: v = 64'h000C1C3C6C7E0C00;   5: v = 64'h007E607C06663C00;
         6: v = 64'h003C607C66663C00;   7: v = 64'h007E060C18181800;
         8: v = 64'h003C663C66663C00;   9: v = 64'h003C663E060C3800;
         10: v = 64'h00183C667E666600;  11: v = 64'h007C667C66667C00;
         12: v = 64'h003C666060663C00;  13: v = 64'h00786C66666C7800;
         14: v = 64'h007E607C60607E00;  15: v = 64'h007E607C60606000;
         16: v = 64'h00007E007E000000;  17: v = 64'h007C667C786C6600;
         default: v = 64'h0;
      endcase
      return v[63-8*r -: 8];
   endfunction

   function automatic logic [11:0] colour(input int px, input int py, input logic de_v);
      int cx, cy, ch, rw, g;
      logic [15:0] v;
      logic [7:0] bits;
      if (!de_v) return 12'h000;
      if (px < X0 || px >= X0 + 192 || py < Y0 || py >= Y0 + 96) return 12'h000;
      cx = px - X0;
      cy = py - Y0;
      ch = cx / 32;
      rw = cy / 32;
      v = rw == 0 ? ma : rw == 1 ? mb : mr;
      g = ch == 0 ? (rw == 0 ? 10 : rw == 1 ? 11 : 17) : ch == 1 ? 16 : int'((v >> (4 * (5 - ch))) & 16'hF);
      bits = font_row(g, (cy % 32) / 4);
      if (!bits[7 - (cx % 32) / 4]) return BG;
      return (ZERO_EN && rw == 2 && mr == 16'h0) ? 12'h0F0 : FG;
   endfunction

   task automatic set_pix(input int px, input int py);
      x = 10'(px);
      y = 10'(py);
      de_in = px < 640 && py < 480;
      hs_in = !(px >= 656 && px < 752);
      vs_in = !(py >= 490 && py < 492);
   endtask

   task automatic tick(input logic stb);
      pix_stb = stb;
      @(posedge clk);
      if (reset) begin
         m_out = IDLE;
         m_s1 = IDLE;
         ma = 16'h0; mb = 16'h0; mr = 16'h0;
      end else if (stb) begin
         m_out = m_s1;
         m_s1 = {colour(int'(x), int'(y), de_in), hs_in, vs_in};
         if (x == 10'd0 && y == 10'd480) begin
            ma = op_a; mb = op_b; mr = result;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      set_pix(X0 + 40, Y0 + 10);
      for (int i = 0; i < 5; i++) begin
         tick(i[0]);
         checks++;
         if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            failures++;
            $display("FAIL reset_levels cyc=%0d got hs=%b vs=%b rgb=%h exp hs=1 vs=1 rgb=000", i, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
         end
      end
      reset = 1'b0;
      set_pix(100, 10);
      tick(1'b1);
      tick(1'b1);
      set_pix(700, 10);
      tick(1'b1);
      checks++;
      if (vga_hs !== 1'b1) begin failures++; $display("FAIL hs_latency_s1 got %b exp 1", vga_hs); end
      tick(1'b0);
      checks++;
      if (vga_hs !== 1'b1) begin failures++; $display("FAIL hs_latency_nostb got %b exp 1", vga_hs); end
      tick(1'b1);
      checks++;
      if (vga_hs !== 1'b0) begin failures++; $display("FAIL hs_latency_s2 got %b exp 0", vga_hs); end
   endtask

   task automatic test_blanking;
      op_a = 16'($urandom); op_b = 16'($urandom); result = 16'($urandom);
      for (int i = 0; i < 2500; i++) begin
         set_pix($urandom_range(799, 0), $urandom_range(524, 0));
         tick(($urandom % 4) != 0);
         checks++;
         if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== m_out) begin
            failures++;
            $display("FAIL blank_random i=%0d got %h exp %h", i, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, m_out);
         end
      end
      set_pix(X0 + 1, Y0);
      tick(1'b1);
      tick(1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== BG) begin
         failures++;
         $display("FAIL box_top_bg got %h exp %h", {vga_r, vga_g, vga_b}, BG);
      end
   endtask

   task automatic test_snapshot;
      logic [7:0] one_row;
      logic [11:0] want;
      op_a = 16'h1234; op_b = 16'($urandom); result = 16'($urandom);
      set_pix(0, 480);
      tick(1'b1);
      op_a = 16'hABCD;
      set_pix(0, 480);
      tick(1'b0);
      set_pix(1, 480);
      tick(1'b1);
      op_a = 16'hFFFF;
      for (int i = 0; i < 400; i++) begin
         set_pix(X0 + $urandom_range(191, 0), Y0 + $urandom_range(31, 0));
         tick(1'b1);
         checks++;
         if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== m_out) begin
            failures++;
            $display("FAIL snapshot_row_a i=%0d got %h exp %h", i, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, m_out);
         end
      end
      one_row = 8'h18;
      for (int fc = 0; fc < 8; fc++) begin
         set_pix(X0 + 64 + 4 * fc, Y0 + 4);
         tick(1'b1);
         tick(1'b1);
         want = one_row[7 - fc] ? FG : BG;
         checks++;
         if ({vga_r, vga_g, vga_b} !== want) begin
            failures++;
            $display("FAIL digit1_row1 fcol=%0d got %h exp %h", fc, {vga_r, vga_g, vga_b}, want);
         end
      end
   endtask

   task automatic test_edges;
      int px[6] = '{X0 + 192, X0 + 191, X0 + 10, X0 + 10, X0 - 1, X0};
      int py[6] = '{Y0 + 10, Y0 + 10, Y0 + 96, Y0 + 95, Y0, Y0 - 1};
      logic [11:0] got;
      for (int i = 0; i < 6; i++) begin
         set_pix(px[i], py[i]);
         tick(1'b1);
         tick(1'b1);
         got = {vga_r, vga_g, vga_b};
         checks++;
         if ({got, vga_hs, vga_vs} !== m_out) begin
            failures++;
            $display("FAIL edge_model x=%0d y=%0d got %h exp %h", px[i], py[i], got, m_out[13:2]);
         end
         checks++;
         if ((i == 1 || i == 3) ? (got !== BG && got !== FG) : (got !== 12'h000)) begin
            failures++;
            $display("FAIL edge_class x=%0d y=%0d got %h", px[i], py[i], got);
         end
      end
   endtask

   task automatic test_stall;
      logic [13:0] held;
      for (int r = 0; r < 20; r++) begin
         set_pix(X0 + $urandom_range(191, 0), Y0 + $urandom_range(95, 0));
         tick(1'b1);
         set_pix(X0 + $urandom_range(191, 0), Y0 + $urandom_range(95, 0));
         tick(1'b1);
         held = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
         for (int s = 0; s < 3; s++) begin
            set_pix($urandom_range(799, 0), $urandom_range(524, 0));
            tick(1'b0);
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== held) begin
               failures++;
               $display("FAIL stall_hold r=%0d s=%0d got %h exp %h", r, s, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, held);
            end
         end
         for (int k = 0; k < 2; k++) begin
            set_pix(X0 + $urandom_range(191, 0), Y0 + $urandom_range(95, 0));
            tick(1'b1);
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== m_out) begin
               failures++;
               $display("FAIL stall_resume r=%0d k=%0d got %h exp %h", r, k, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, m_out);
            end
         end
      end
   endtask

   task automatic test_zero_flag;
      logic [11:0] want;
      for (int p = 0; p < 2; p++) begin
         result = p == 0 ? 16'h0000 : 16'h0001;
         op_a = 16'($urandom); op_b = 16'($urandom);
         set_pix(1, 480);
         tick(1'b1);
         set_pix(0, 480);
         tick(1'b1);
         set_pix(X0 + 36, Y0 + 72);
         tick(1'b1);
         tick(1'b1);
         want = (p == 0 && ZERO_EN) ? 12'h0F0 : FG;
         checks++;
         if ({vga_r, vga_g, vga_b} !== want) begin
            failures++;
            $display("FAIL zero_flag_eq result=%h got %h exp %h", result, {vga_r, vga_g, vga_b}, want);
         end
         for (int i = 0; i < 150; i++) begin
            set_pix(X0 + $urandom_range(191, 0), Y0 + 64 + $urandom_range(31, 0));
            tick(1'b1);
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== m_out) begin
               failures++;
               $display("FAIL zero_flag_row result=%h i=%0d got %h exp %h", result, i, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, m_out);
            end
         end
      end
   endtask

   task automatic test_reset_snapshot;
      op_a = 16'h5A5A; op_b = 16'hC3C3; result = 16'h9999;
      set_pix(0, 480);
      reset = 1'b1;
      tick(1'b1);
      reset = 1'b0;
      set_pix(5, 480);
      tick(1'b1);
      for (int i = 0; i < 300; i++) begin
         set_pix(X0 + 64 + $urandom_range(127, 0), Y0 + $urandom_range(95, 0));
         tick(($urandom % 3) != 0);
         checks++;
         if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== m_out) begin
            failures++;
            $display("FAIL reset_beats_snapshot i=%0d got %h exp %h", i, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, m_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_blanking();
      test_snapshot();
      test_edges();
      test_stall();
      test_zero_flag();
      test_reset_snapshot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_hex_overlay.md
# vga_hex_overlay

Pixel-rendering stage that sits directly downstream of the 640x480 VGA timing generator. It consumes the generator's x/y/hs/vs/de and the ALU operands/result, and draws a 3-line hexadecimal readout ("A=hhhh", "B=hhhh", "R=hhhh") in a fixed box on screen. It drives the Nexys A7 4-bit-per-channel VGA pins. Sync outputs are delayed so they stay aligned with the colour pipeline.

## Interface
- X0, 64: left edge of the text box in pixels (10 bits).
- Y0, 64: top edge of the text box in lines (10 bits).
- FG, 12'hFFF: glyph colour {R,G,B}, 4 bits each.
- BG, 12'h008: box background colour.
- CLK100MHZ  in  1  board clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- pix_stb  in  1  pixel strobe; the pipeline advances only when it is 1.
- x  in  10  current pixel column from the timing generator.
- y  in  10  current line from the timing generator.
- hs_in  in  1  hsync, active low, undelayed.
- vs_in  in  1  vsync, active low, undelayed.
- de_in  in  1  active video.
- op_a  in  16  ALU operand A.
- op_b  in  16  ALU operand B.
- result  in  16  ALU result.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- vga_hs  out  1  hsync delayed by 2 strobes.
- vga_vs  out  1  vsync delayed by 2 strobes.

## Operation
- **Snapshot registers** (3 x 16 bits):
  - Loaded from op_a/op_b/result on the cycle where pix_stb=1 and x==0 and y==480 (start of vertical blanking).
  - This gives a tear-free display; the displayed values change once per frame only.
  - Reset clears all three to 0.
- **Box geometry**:
  - The font is 8x8 and each font pixel is drawn as a 4x4 block, so each character cell is 32x32 pixels.
  - The box is 6 columns x 3 rows = 192x96 pixels.
  - in_box = (x >= X0) && (x < X0+192) && (y >= Y0) && (y < Y0+96).
  - Subtractions are done at 10-bit width, only when in_box is true.
  - col = (x-X0)>>5 (0..5); fcol = ((x-X0)>>2)&7.
  - row = (y-Y0)>>5 (0..2); frow = ((y-Y0)>>2)&7.
- **Glyph codes** (5 bits): 0-15 are hex digits 0-F, 16 is '=', 17 is 'R', 31 is blank (all zeros).
  - col 0 is the row label: A (code 10), B (code 11), or R (code 17).
  - col 1 is '=' (code 16).
  - cols 2..5 are nibbles [15:12], [11:8], [7:4], [3:0] of the row's snapshot.
- **Font ROM**: combinational case on {code, frow}, returning 8 bits; bit 7 is the leftmost pixel. Unlisted codes return 0.
- **Pipeline** (registers update only when pix_stb=1; otherwise all hold):
  - S1 registers code, frow, fcol, in_box, de_in, hs_in, vs_in.
  - S2 registers the colour and the delayed syncs:
    - if !de_s1: colour 0;
    - else if in_box_s1 and rom[7-fcol_s1]: FG;
    - else if in_box_s1: BG;
    - else 0.
- **Reset**:
  - vga_r/g/b = 0; vga_hs = vga_vs = 1 (inactive).
  - All S1 state is cleared, with hs/vs = 1 and de = 0.
  - Reset mid-frame takes effect on the next edge regardless of pix_stb. Output resumes correctly 2 strobes after reset is released.

## Timing
- Latency from x/y/hs/vs/de to the VGA pins is exactly 2 pix_stb strobes. hs/vs/rgb stay mutually aligned.
- The colour is forced to 0 whenever the delayed de is 0; no colour is ever driven during blanking.
- **Snapshot timing**: inputs sampled at (x=0, y=480) are first displayed in the next frame's active area.
  - If reset and the snapshot condition coincide, reset wins.
- **Box edges**:
  - Pixel x=X0+191 is the last box column; x=X0+192 is outside the box.
  - y=Y0+95 is the last box line.
- **Parameter constraint**: X0+192 ≤ 640 and Y0+96 ≤ 480. This is a parameter constraint and is not checked in RTL.

## Configuration
- VGA_HEX_OVERLAY_ZERO_FLAG_EN:
  - When defined, row 2 (R) is drawn in colour 12'h0F0 instead of FG whenever the snapshotted result is 16'h0000. A 1-bit zero flag is registered together with the snapshot.
  - When undefined, all rows use FG and no flag register exists.

## Test plan
- **Reset sync levels**: hold reset for 5 cycles with pix_stb toggling. Expect vga_hs=vga_vs=1 and rgb=0 throughout. After release, vga_hs falls exactly 2 strobes after hs_in falls.
- **Blanking colour**: drive the full timing generator for 1 frame. Expect rgb=0 for every strobe where the delayed de=0, and rgb=BG at (X0+1, Y0) (the blank top font row of 'A').
- **Snapshot and digit 1**: set op_a=16'h1234 before y=480, then change it to 16'hFFFF mid-next-frame. The frame displays 1234, not FFFF.
  - Pixel check at font pixel (col 2, frow 1) against the '1' ROM row gives FG/BG exactly as the ROM bits dictate.
- **Box edges**: at x=X0+192 and at y=Y0+96, expect rgb=0 (outside the box, de=1). At x=X0+191, expect BG or FG.
- **pix_stb stall**: hold pix_stb=0 for 3 cycles mid-line. Expect outputs unchanged during the stall and latency of 2 strobes preserved afterwards.
- **Zero flag (macro on)**: result=0 gives R-row glyph pixels of 12'h0F0. Result=16'h0001 gives FG.
